// File: rtl/seq_magnitude_comparator.sv
// Sequential MSB-first magnitude comparator, DIGIT bits per cycle, early exit on first unequal slice.
// Latency = cycles (1..NSLICE) edges; in_ready only in IDLE; result held in DONE until out_ready.
module seq_magnitude_comparator #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4,
    parameter int CW    = $clog2(WIDTH / DIGIT) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             lt,
    output logic             gt,
    output logic             eq,
    output logic [CW-1:0]    cycles
);
    localparam int NSLICE = WIDTH / DIGIT;
    localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};

    generate
        if (WIDTH % DIGIT != 0) begin : g_bad_width
            $error("WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] xr;
    logic [WIDTH-1:0] yr;
    logic [IW-1:0]    idx;
    logic [DIGIT-1:0] xs;
    logic [DIGIT-1:0] ys;

    assign xs        = xr[32'(idx) * DIGIT +: DIGIT];
    assign ys        = yr[32'(idx) * DIGIT +: DIGIT];
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = SCAN;
            SCAN: if (xs != ys || idx == '0) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            xr     <= '0;
            yr     <= '0;
            idx    <= '0;
            lt     <= 1'b0;
            gt     <= 1'b0;
            eq     <= 1'b0;
            cycles <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Flipping both sign bits maps two's-complement order onto unsigned order.
                        xr     <= signed_mode ? (x ^ MSB) : x;
                        yr     <= signed_mode ? (y ^ MSB) : y;
                        idx    <= IW'(NSLICE - 1);
                        cycles <= '0;
                        lt     <= 1'b0;
                        gt     <= 1'b0;
                        eq     <= 1'b0;
                    end
                end
                SCAN: begin
                    cycles <= cycles + CW'(1);
                    if (xs > ys)
                        gt <= 1'b1;
                    else if (xs < ys)
                        lt <= 1'b1;
                    else if (idx == '0)
                        eq <= 1'b1;
                    else
                        idx <= idx - IW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Directed bench for seq_magnitude_comparator (WIDTH=32, DIGIT=4) with hand-computed expectations.
module tb_seq_magnitude_comparator;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x;
    logic [31:0] y;
    logic        signed_mode;
    logic        out_valid;
    logic        out_ready;
    logic        lt;
    logic        gt;
    logic        eq;
    logic [3:0]  cycles;

    int checks = 0;
    int errors = 0;

    seq_magnitude_comparator #(.WIDTH(32), .DIGIT(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .signed_mode(signed_mode), .out_valid(out_valid),
        .out_ready(out_ready), .lt(lt), .gt(gt), .eq(eq), .cycles(cycles)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transaction: flags expected as {lt,gt,eq}; leaves the DUT in DONE if ordy=0.
    task automatic txn(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic sm, input logic ordy, input logic [2:0] flags, input int ecyc);
        int lat;
        @(negedge clk);
        x = a; y = b; signed_mode = sm; in_valid = 1'b1; out_ready = ordy;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        x = ~a; y = ~b; signed_mode = ~sm;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(ecyc));
        chk({tag, "_flags"}, 32'({lt, gt, eq}), 32'(flags));
        chk({tag, "_cycles"}, 32'(cycles), 32'(ecyc));
        if (ordy) begin
            @(negedge clk);
            chk({tag, "_ov_one_cycle"}, 32'(out_valid), 32'd0);
            chk({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        x = '0; y = '0; signed_mode = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_flags", 32'({lt, gt, eq}), 32'd0);
        chk("rst_cycles", 32'(cycles), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        txn("u_80_vs_7f", 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 3'b010, 1);
        txn("s_80_vs_7f", 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b1, 3'b100, 1);
        txn("s_ff_vs_00", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1, 3'b100, 1);
        txn("u_ff_vs_00", 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 3'b010, 1);
        txn("u_eq",       32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 3'b001, 8);
        txn("s_eq",       32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1, 3'b001, 8);
        txn("u_1_vs_2",   32'h0000_0001, 32'h0000_0002, 1'b0, 1'b1, 3'b100, 8);
        txn("u_f0_vs_e0", 32'h00F0_0000, 32'h00E0_0000, 1'b0, 1'b1, 3'b010, 3);
        txn("s_m1_vs_m2", 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 1'b1, 3'b010, 8);

        // Backpressure: hold result with new operands offered, then release.
        txn("bp", 32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 3'b010, 8);
        x = 32'h1000_0000; y = 32'h2000_0000; signed_mode = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_hold", 32'({lt, gt, eq, cycles}), 32'({3'b010, 4'd8}));
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_idle_in_ready", 32'(in_ready), 32'd1);
        chk("bp_idle_out_valid", 32'(out_valid), 32'd0);
        chk("bp_idle_hold", 32'({lt, gt, eq, cycles}), 32'({3'b010, 4'd8}));
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_new_accepted", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("bp_new_out_valid", 32'(out_valid), 32'd1);
        chk("bp_new_result", 32'({lt, gt, eq, cycles}), 32'({3'b100, 4'd1}));

        // Reset during the 4th SCAN cycle of an equal-operand compare.
        @(negedge clk);
        x = 32'h5555_5555; y = 32'h5555_5555; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_scan_cycles", 32'(cycles), 32'd3);
        rst = 1'b1;
        #1;
        chk("arst_flags", 32'({lt, gt, eq}), 32'd0);
        chk("arst_cycles", 32'(cycles), 32'd0);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        chk("arst_no_result", 32'(out_valid), 32'd0);
        rst = 1'b0;
        txn("post_rst", 32'hABCD_0000, 32'hABCD_0001, 1'b0, 1'b1, 3'b100, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
